// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with an 8-level circular return stack.
// Resolves NEXT/SKIP/GOTO/CALL/RETURN/HOLD once per qualified instruction cycle.
module pc_stack_unit #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 13,
    parameter int TGT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [TGT_W-1:0] target,
    input  logic             skip_cond,
    output logic [PC_W-1:0]  pc_out,
    output logic [3:0]       depth,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             ovf,
    output logic             unf
);
    localparam int SP_W = $clog2(DEPTH);
    localparam logic [3:0] FULL_DEPTH = 4'(DEPTH);

    localparam logic [2:0] OP_SKIP = 3'b001;
    localparam logic [2:0] OP_GOTO = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HOLD = 3'b101;

    logic [DEPTH-1:0][PC_W-1:0] stack;
    logic [SP_W-1:0]            sp;
    logic [SP_W-1:0]            sp_dec;
    logic [PC_W-1:0]            pc_inc;
    logic [PC_W-1:0]            pc_skip;
    logic [PC_W-1:0]            jump;

    assign stack_full  = (depth == FULL_DEPTH);
    assign stack_empty = (depth == 4'd0);

    assign sp_dec  = sp - SP_W'(1);
    assign pc_inc  = pc_out + PC_W'(1);
    assign pc_skip = pc_out + PC_W'(2);
    // Jumps keep the page of the current pc, not of pc+1.
    assign jump    = {pc_out[PC_W-1:TGT_W], target};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out <= '0;
            sp     <= '0;
            depth  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            stack  <= '0;
        end else if (step) begin
            case (op)
                OP_SKIP: pc_out <= skip_cond ? pc_skip : pc_inc;
                OP_GOTO: pc_out <= jump;
                OP_CALL: begin
                    // A full stack silently overwrites its oldest entry.
                    stack[sp] <= pc_inc;
                    sp        <= sp + SP_W'(1);
                    pc_out    <= jump;
                    if (stack_full) ovf   <= 1'b1;
                    else            depth <= depth + 4'd1;
                end
                OP_RET: begin
                    // An empty stack still pops whatever stale entry sits below sp.
                    sp     <= sp_dec;
                    pc_out <= stack[sp_dec];
                    if (stack_empty) unf   <= 1'b1;
                    else             depth <= depth - 4'd1;
                end
                OP_HOLD: pc_out <= pc_out;
                default: pc_out <= pc_inc;
            endcase
        end
    end
endmodule
